// File: rtl/key_filter.sv
// key_filter: eight-button debouncer with a small memory-mapped register
// block (pending, mask, level, press counter) and a level interrupt.
//
// Ports
//   clk_in         system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   key_raw        raw buttons, active-low, asynchronous and bouncing
//   key_clean      debounced button level, active-low (drives GPIO user_key)
//   KEY_WE         per-byte-lane write enable from the bus bridge
//   KEY_Addr       bus address, only bits [3:2] are decoded
//   KEY_WriteData  bus write data
//   KEY_ReadData   combinational read data for KEY_Addr
//   irq            level interrupt, |(PENDING & MASK)
//
// Register map (KEY_Addr[3:2])
//   0 PENDING[7:0]    read / write-1-to-clear, set on press events
//   1 MASK[7:0]       read / write (byte lane 0 only)
//   2 LEVEL[7:0]      read-only, ~key_clean (1 = pressed)
//   3 PRESS_CNT[31:0] read / write per byte lane, counts press events
module key_filter #(
  parameter int unsigned CNT_MAX = 500000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  key_raw,
  output logic [7:0]  key_clean,
  input  logic [3:0]  KEY_WE,
  input  logic [31:0] KEY_Addr,
  input  logic [31:0] KEY_WriteData,
  output logic [31:0] KEY_ReadData,
  output logic        irq
);

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_MASK    = 2'd1,
    REG_LEVEL   = 2'd2,
    REG_CNT     = 2'd3
  } reg_sel_e;

  // Last count value of the stability window; reaching it with a mismatch
  // still present commits the new level.
  localparam logic [19:0] CNT_LAST = 20'(CNT_MAX - 1);

  // Synchronizer and debounce state
  logic [7:0]       s1_q, s2_q;
  logic [7:0]       key_clean_q, key_clean_d;
  logic [7:0][19:0] cnt_q, cnt_d;

  // Register block state
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] press_cnt_q, press_cnt_d;

  // Per-cycle press events and their population count
  logic [7:0] press;
  logic [3:0] press_num;

  reg_sel_e sel;
  logic     wr_any;

  // Only KEY_Addr[3:2] selects a register; the rest is ignored on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{KEY_Addr[31:4], KEY_Addr[1:0]};

  assign sel    = reg_sel_e'(KEY_Addr[3:2]);
  assign wr_any = |KEY_WE;

  // ---------------------------------------------------------------------------
  // Debounce: a key's counter runs only while the synchronized input differs
  // from the committed level; any agreement restarts the window from zero.
  // A press is the 1->0 commit of key_clean.
  // ---------------------------------------------------------------------------
  always_comb begin
    key_clean_d = key_clean_q;
    cnt_d       = '0;
    press       = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (s2_q[i] != key_clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          key_clean_d[i] = s2_q[i];
          press[i]       = key_clean_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  always_comb begin
    press_num = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      press_num = press_num + {3'b000, press[i]};
    end
  end

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  // Clear first, then OR in new events so a same-cycle set beats the clear.
  always_comb begin
    pend_d = pend_q;
    if (sel == REG_PENDING && KEY_WE[0]) begin
      pend_d = pend_q & ~KEY_WriteData[7:0];
    end
    pend_d = pend_d | press;
  end

  always_comb begin
    mask_d = mask_q;
    if (sel == REG_MASK && KEY_WE[0]) begin
      mask_d = KEY_WriteData[7:0];
    end
  end

  // A bus write to the counter takes the whole cycle: lanes without an
  // enable hold, and that cycle's press increment is discarded.
  always_comb begin
    press_cnt_d = press_cnt_q + {28'd0, press_num};
    if (sel == REG_CNT && wr_any) begin
      press_cnt_d = press_cnt_q;
      for (int unsigned b = 0; b < 4; b++) begin
        if (KEY_WE[b]) begin
          press_cnt_d[8*b +: 8] = KEY_WriteData[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q        <= '1;
      s2_q        <= '1;
      key_clean_q <= '1;
      cnt_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      press_cnt_q <= '0;
    end else begin
      s1_q        <= key_raw;
      s2_q        <= s1_q;
      key_clean_q <= key_clean_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    KEY_ReadData = '0;
    unique case (sel)
      REG_PENDING: KEY_ReadData = {24'd0, pend_q};
      REG_MASK:    KEY_ReadData = {24'd0, mask_q};
      REG_LEVEL:   KEY_ReadData = {24'd0, ~key_clean_q};
      REG_CNT:     KEY_ReadData = press_cnt_q;
      default:     KEY_ReadData = '0;
    endcase
  end

  assign key_clean = key_clean_q;
  assign irq       = |(pend_q & mask_q);

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter CNT_MAX, default 500000, is the debounce stability window in clk_in cycles; the legal range is 2..1048576.
REQ-002 Port clk_in, input, 1 bit, is the single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit, is a synchronous, active-high reset.
REQ-004 Port key_raw, input, 8 bits, carries the raw board buttons (active-low: 0 = pressed; asynchronous, bouncing).
REQ-005 Port key_clean, output, 8 bits, is the debounced button level (active-low) and SHALL drive the GPIO user_key input.
REQ-006 Port KEY_WE, input, 4 bits, is the per-byte-lane write enable from the bridge.
REQ-007 Port KEY_Addr, input, 32 bits, is the bus address; only bits [3:2] SHALL be decoded.
REQ-008 Port KEY_WriteData, input, 32 bits, is the bus write data.
REQ-009 Port KEY_ReadData, output, 32 bits, is the combinational read data for KEY_Addr.
REQ-010 Port irq, output, 1 bit, is the level interrupt request to the CPU.

Function
REQ-011 Each key_raw bit SHALL pass through a 2-flop synchronizer (s1, s2); key_clean SHALL be computed from s2 only.
REQ-012 Each key SHALL have a 20-bit stability counter that works as follows:
- If s2 equals key_clean, the counter SHALL clear to 0.
- If s2 differs from key_clean and counter < CNT_MAX-1, the counter SHALL increment.
- If s2 differs from key_clean and counter == CNT_MAX-1, key_clean SHALL take the s2 value and the counter SHALL clear.
REQ-013 Latency: when raw changes before edge k and then holds, key_clean SHALL change at edge k+1+CNT_MAX.
REQ-014 A mismatch that lasts fewer than CNT_MAX cycles of s2 SHALL NOT change key_clean (bounce rejection). Any return to the current key_clean value restarts the window from 0.
REQ-015 A press event on key i SHALL occur at the edge where key_clean[i] changes from 1 to 0. A release (0 to 1) SHALL NOT generate an event.
REQ-016 The register map, selected by KEY_Addr[3:2], SHALL be:
- 0: PENDING[7:0] (read / write-1-to-clear).
- 1: MASK[7:0] (read/write).
- 2: LEVEL, which reads as {24'b0, ~key_clean} (active-high pressed; read-only).
- 3: PRESS_CNT[31:0] (read/write).
- Unused upper bits SHALL read as 0.
REQ-017 A press event on key i SHALL set PENDING[i]. A write to address 0 with KEY_WE[0]=1 SHALL clear every PENDING bit whose KEY_WriteData bit is 1.
REQ-018 If a set and a clear hit the same PENDING bit in the same cycle, the set SHALL win (the bit reads 1).
REQ-019 A write to address 1 SHALL update MASK[7:0] only when KEY_WE[0]=1; other lanes SHALL be ignored.
REQ-020 PRESS_CNT SHALL increment by the number of press events in that cycle (0..8) and SHALL wrap modulo 2^32.
REQ-021 A write to address 3 SHALL load each byte lane whose KEY_WE bit is set. In that cycle the write SHALL win and that cycle's increment SHALL be discarded.
REQ-022 Writes to address 2 SHALL have no effect.
REQ-023 irq SHALL be registered-free combinational logic: irq = |(PENDING & MASK).
REQ-024 KEY_ReadData SHALL reflect state after the most recent edge, with no read side effects.

Reset
REQ-025 When reset=1 at an edge, the block SHALL load these values:
- s1, s2 and key_clean to 8'hFF.
- All counters, PENDING, MASK and PRESS_CNT to 0.
- As a result, irq SHALL read 0.
REQ-026 Reset SHALL override simultaneous bus writes and press events.
REQ-027 A key held pressed through reset SHALL be re-debounced after reset is released and SHALL produce exactly one press event.

Verification (use CNT_MAX=4)
REQ-028 Hold key_raw=8'hFE from edge k onward -> key_clean=8'hFE at edge k+5; PENDING=8'h01 and PRESS_CNT=1 at the same edge; irq stays 0 (MASK=0).
REQ-029 Toggle key_raw[0] 0/1 every 2 cycles for 40 cycles -> key_clean stays 8'hFF; PENDING stays 0.
REQ-030 Set MASK=8'h0F, then press keys 0 and 3 in the same cycle -> PENDING=8'h09, PRESS_CNT increments by 2, irq=1. Write 8'h09 to address 0 -> PENDING=0, irq=0.
REQ-031 In the cycle a press event sets PENDING[2], write 8'h04 to address 0 -> PENDING[2] reads 1.
REQ-032 Set PRESS_CNT=32'hFFFFFFFF, then press one key -> PRESS_CNT=0. Also write to address 3 with KEY_WE=4'b0001 and data 32'h12345678 in a press-event cycle -> low byte becomes 8'h78, upper bytes are unchanged, and the increment is dropped.
REQ-033 Hold key 1 pressed and assert reset for 1 cycle mid-count and after debounce -> key_clean=8'hFF and all registers 0 after the reset edge. Exactly one new event follows, 5 edges after reset is released.
